// File: rtl/matrix_result_reader_if.sv
// Output byte stream from the matrix result reader to the host.
// One byte moves on each rising edge where out_valid && out_ready.
interface matrix_result_reader_if #(
  parameter int ELEM_W = 8
) ();
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/matrix_result_reader.sv
// Readout engine for the matrix coprocessor ALU result.
// On start it snapshots the result matrix, overflow flag and active
// dimension, then streams the n x n sub-matrix row-major (row stride
// DIM_MAX), one byte per handshake, followed by a single status byte.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// SEND   | presenting shadow element (r,c); advance on handshake
// STATUS | presenting {0, overflow} with out_last; advance on handshake
// DONE   | one-cycle done pulse, then back to IDLE
module matrix_result_reader #(
  parameter int ELEM_W  = 8,
  parameter int DIM_MAX = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] C_flat_i,
  input  logic                              overflow_flag_i,
  input  logic [2:0]                        n_i,
  matrix_result_reader_if.master            out_if,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int NW = DIM_MAX * DIM_MAX * ELEM_W;

  typedef enum logic [1:0] {IDLE, SEND, STATUS, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        r_q, r_d;
  logic [2:0]        c_q, c_d;
  logic [2:0]        n_q, n_d;
  logic [NW-1:0]     shadow_q, shadow_d;
  logic              ovf_q, ovf_d;
  logic [ELEM_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        n_clamp;
  logic              hs;

  // Element (r,c) of a captured matrix; stride is fixed at DIM_MAX.
  function automatic logic [ELEM_W-1:0] elem(input logic [NW-1:0] m,
                                             input logic [2:0] r,
                                             input logic [2:0] c);
    int idx;
    idx = int'(r) * DIM_MAX + int'(c);
    return m[idx*ELEM_W +: ELEM_W];
  endfunction

  // Out-of-range dimensions (0 and above DIM_MAX) fall back to full size.
  always_comb begin
    n_clamp = n_i;
    if (n_i == 3'd0 || int'(n_i) > DIM_MAX) n_clamp = 3'(DIM_MAX);
  end

  assign hs = valid_q && out_if.out_ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    n_d      = n_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        if (start_i) begin
          shadow_d = C_flat_i;
          ovf_d    = overflow_flag_i;
          n_d      = n_clamp;
          r_d      = 3'd0;
          c_d      = 3'd0;
          data_d   = C_flat_i[ELEM_W-1:0];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = SEND;
        end
      end

      SEND: begin
        if (hs) begin
          if (c_q == n_q - 3'd1) begin
            c_d = 3'd0;
            if (r_q == n_q - 3'd1) begin
              data_d  = {{(ELEM_W-1){1'b0}}, ovf_q};
              last_d  = 1'b1;
              state_d = STATUS;
            end else begin
              r_d    = r_q + 3'd1;
              data_d = elem(shadow_q, r_q + 3'd1, 3'd0);
            end
          end else begin
            c_d    = c_q + 3'd1;
            data_d = elem(shadow_q, r_q, c_q + 3'd1);
          end
        end
      end

      STATUS: begin
        if (hs) begin
          data_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        r_d     = 3'd0;
        c_d     = 3'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= 3'd0;
      c_q      <= 3'd0;
      n_q      <= 3'd0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      n_q      <= n_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: doc/matrix_result_reader.md
# matrix_result_reader

Readout engine on the output side of the matrix coprocessor ALU. On a start pulse it captures the ALU result matrix (`C_flat`, 25 signed 8-bit elements, row-major, row stride 5) and the overflow flag. It then streams the active n×n sub-matrix to the host, one byte per valid/ready handshake, followed by one status byte. It is the consumer counterpart of the path that loads `A_flat`/`B_flat` into the ALU and triggers an operation.

## Interface

Parameters:
- `ELEM_W`, 8, element width in bits.
- `DIM_MAX`, 5, physical matrix dimension; also the row stride of `C_flat`.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: one-cycle request to capture and stream; sampled only in IDLE.
- `C_flat` input 200: ALU result; element (r,c) at bits `[(r*5+c)*8 +: 8]`.
- `overflow_flag` input 1: ALU overflow, captured with `C_flat`.
- `n` input 3: active dimension, captured on start; 1..5 valid; 0, 6 and 7 are clamped to 5.
- `out_data` output 8: current byte.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: host accepts a byte; a handshake is `out_valid && out_ready` on a rising edge.
- `out_last` output 1: high with the status byte only.
- `busy` output 1: high from the cycle after start until the return to IDLE.
- `done` output 1: one-cycle pulse after the status byte is accepted.

## Operation

- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0; state IDLE; row/col counters 0.
- States: IDLE, SEND, STATUS, DONE.
- IDLE, `start`=1:
  - Latch `C_flat` into a 200-bit shadow register, `overflow_flag` into a 1-bit register, and the clamped `n` into a 3-bit register.
  - Set r=c=0 and go to SEND.
  - `start` in any other state is ignored.
- SEND:
  - `out_valid`=1 and `out_data` = shadow element (r,c).
  - On a handshake: if c<n-1, increment c; otherwise c=0 and increment r.
  - After the handshake on (n-1,n-1), go to STATUS.
- STATUS:
  - `out_data` = {7'b0, captured overflow}, `out_valid`=1, `out_last`=1.
  - On a handshake, go to DONE.
- DONE: `done`=1 and `out_valid`=0 for one cycle, then go to IDLE.
- Elements are sent raw (two's complement, unmodified). Stride is always 5, independent of n.
- Changes on `C_flat`, `overflow_flag` or `n` after capture have no effect on the current stream.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold steady and `out_valid` stays 1.
- `out_valid` never drops without a handshake, except on reset.
- Reset mid-operation aborts the stream: the next edge produces reset values, no `done` pulse is issued, and the shadow contents are irrelevant.

## Timing

- `start` sampled at edge 0 → `busy`=1 and `out_valid`=1 with element (0,0) after edge 0. Latency is 1 cycle.
- `out_ready` held high gives one byte per cycle: n² element beats, then 1 status beat.
- For n=5: element beats occupy cycles 1–25, the status beat cycle 26, `done` cycle 27, and IDLE is reached at cycle 28.
- A new `start` is accepted at cycle 28 or later.
- A `start` coincident with `done` is ignored.
- `busy` falls in the same cycle that `done` falls (busy covers SEND, STATUS and DONE).
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid` or `out_data`.

## Test plan

- `C_flat` byte k = k (k=0..24), n=5, overflow=0, `out_ready`=1, `start` pulse → bytes 0x00..0x18 on cycles 1–25; status 0x00 with `out_last` on cycle 26; `done` on cycle 27.
- Same `C_flat`, n=3 → bytes 0,1,2,5,6,7,10,11,12; then status with `out_last`; `done` 2 cycles after the last element.
- Backpressure, n=5: drop `out_ready` for 3 cycles while element 4 is presented → `out_data` stays 0x04 and `out_valid` stays 1 throughout; the stream resumes with 0x05; total duration grows by 3 cycles.
- `overflow_flag`=1 at start, forced to 0 during the stream, and `C_flat` changed mid-stream → status byte 0x01; the element stream matches the captured values.
- `start` pulsed at cycles 5 and 27 of an n=5 run → both ignored, with exactly 26 beats and one `done`. Separately, n=0 → treated as 5, giving 25 element beats.
- `rst_n`=0 for one cycle after 10 accepted beats → next cycle `out_valid`=0, `busy`=0, `done` never pulses; a following `start` with n=2 streams 0,1,5,6 and the status byte normally.
